// File: rtl/fetch_unit.sv
// Instruction-fetch / program-counter datapath: holds PC, fetches over IMEM_REQ/IMEM_ACK into INSTR.
// Optional acknowledge timeout (halt-opcode substitution + sticky FAULT) under `define FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               PC_RST,
    input  logic                               PC_WRITE,
    input  logic                               PC_SEL,
    input  logic                               BR_SEL,
    input  logic                               FETCH,
    output logic                               IMEM_REQ,
    output logic [ADDR_W-1:0]                  IMEM_ADDR,
    input  logic [DATA_W-1:0]                  IMEM_RDATA,
    input  logic                               IMEM_ACK,
    output logic [DATA_W-1:0]                  INSTR,
    output logic [3:0]                         OPCODE,
    output logic [3:0]                         MM,
    output logic [ADDR_W-1:0]                  PC,
    output logic                               INSTR_VALID,
    output logic                               BUSY,
    output logic                               FAULT,
    output logic                               DBG_STATE,
    output logic [$clog2(TIMEOUT_CYC+1)-1:0]   DBG_TIMER
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] HALT_INSTR = {4'hF, {(DATA_W-4){1'b0}}};

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              timeout_hit;
    logic [ADDR_W-1:0] br_field;

    // Branch targets come only from the latched instruction, never from IMEM_RDATA.
    assign br_field = instr_q[ADDR_W-1:0];

    always_comb begin
        pc_d = pc_q;
        if (PC_RST) begin
            pc_d = '0;
        end else if (PC_WRITE) begin
            if (!PC_SEL)     pc_d = pc_q + ADDR_W'(1);
            else if (BR_SEL) pc_d = br_field;
            else             pc_d = pc_q + br_field;  // two's-complement add == signed offset mod 2^ADDR_W
        end
    end

    // Handshake: IMEM_REQ rises with IMEM_ADDR on FETCH, both held stable until an edge
    // samples IMEM_ACK=1 (IMEM_RDATA valid with it); IMEM_ACK is ignored while no request is open.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (FETCH) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            S_WAIT: begin
                if (IMEM_ACK) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    instr_d = IMEM_RDATA;
                    valid_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    instr_d = HALT_INSTR;
                    valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             in_wait_no_ack;

    // Counts WAIT edges without ACK; the edge after TIMEOUT_CYC such edges times out.
    assign in_wait_no_ack = (state_q == S_WAIT) && !IMEM_ACK;
    assign timeout_hit    = (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        cnt_d   = '0;
        fault_d = fault_q;
        if (in_wait_no_ack) begin
            if (timeout_hit) fault_d = 1'b1;
            else             cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    assign FAULT     = fault_q;
    assign DBG_TIMER = cnt_q;
`else
    assign timeout_hit = 1'b0;
    assign FAULT       = 1'b0;
    assign DBG_TIMER   = '0;
`endif

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = addr_q;
    assign INSTR       = instr_q;
    assign OPCODE      = instr_q[DATA_W-1 -: 4];
    assign MM          = instr_q[DATA_W-5 -: 4];
    assign PC          = pc_q;
    assign INSTR_VALID = valid_q;
    assign BUSY        = (state_q == S_WAIT);
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a behavioural model; build with/without FETCH_TIMEOUT_EN.
module tb_fetch_unit;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int TIMEOUT_CYC = 15;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST, PC_RST, PC_WRITE, PC_SEL, BR_SEL, FETCH, IMEM_ACK;
    logic [DATA_W-1:0] IMEM_RDATA;
    logic IMEM_REQ, INSTR_VALID, BUSY, FAULT, DBG_STATE;
    logic [ADDR_W-1:0] IMEM_ADDR, PC;
    logic [DATA_W-1:0] INSTR;
    logic [3:0] OPCODE, MM;
    logic [CNT_W-1:0] DBG_TIMER;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    logic [ADDR_W-1:0] m_pc = '0, m_addr = '0;
    logic [DATA_W-1:0] m_instr = '0;
    logic m_valid = 1'b0, m_busy = 1'b0, m_fault = 1'b0;
    int m_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RST(RST), .PC_RST(PC_RST), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL),
        .BR_SEL(BR_SEL), .FETCH(FETCH), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RDATA(IMEM_RDATA), .IMEM_ACK(IMEM_ACK), .INSTR(INSTR), .OPCODE(OPCODE),
        .MM(MM), .PC(PC), .INSTR_VALID(INSTR_VALID), .BUSY(BUSY), .FAULT(FAULT),
        .DBG_STATE(DBG_STATE), .DBG_TIMER(DBG_TIMER)
    );

    always #5 CLK = ~CLK;

    // Model of one rising edge, from the block's documented rules.
    task automatic model_edge();
        logic [ADDR_W-1:0] old_pc;
        if (RST) begin
            m_pc = '0; m_instr = '0; m_valid = 1'b0; m_busy = 1'b0;
            m_addr = '0; m_cnt = 0; m_fault = 1'b0; exp_q.delete();
        end else begin
            old_pc = m_pc;
            if (PC_RST) m_pc = '0;
            else if (PC_WRITE) begin
                if (!PC_SEL) m_pc = ADDR_W'(int'(old_pc) + 1);
                else if (BR_SEL) m_pc = m_instr[ADDR_W-1:0];
                else m_pc = ADDR_W'(int'(old_pc) + int'($signed(m_instr[ADDR_W-1:0])));
            end
            m_valid = 1'b0;
            if (!m_busy) begin
                if (FETCH) begin m_busy = 1'b1; m_addr = old_pc; m_cnt = 0; end
            end else if (IMEM_ACK) begin
                m_instr = IMEM_RDATA; m_valid = 1'b1; m_busy = 1'b0; exp_q.push_back(IMEM_RDATA);
            end else if (TO_EN && m_cnt == TIMEOUT_CYC) begin
                m_instr = 32'hF000_0000; m_valid = 1'b1; m_busy = 1'b0; m_fault = 1'b1;
                exp_q.push_back(32'hF000_0000);
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge CLK);
    endtask

    task automatic load_instr(input logic [DATA_W-1:0] d);
        FETCH = 1'b1; step();
        FETCH = 1'b0; IMEM_ACK = 1'b1; IMEM_RDATA = d; step();
        IMEM_ACK = 1'b0;
    endtask

    task automatic set_pc(input int n);
        PC_RST = 1'b1; step(); PC_RST = 1'b0;
        PC_WRITE = 1'b1; PC_SEL = 1'b0;
        repeat (n) step();
        PC_WRITE = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; step(); step(); RST = 1'b0;
        checks++; if (PC !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", PC); end
        checks++; if (INSTR !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", INSTR); end
        checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", IMEM_REQ); end
        checks++; if (IMEM_ADDR !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0", IMEM_ADDR); end
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", INSTR_VALID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", FAULT); end
    endtask

    task automatic test_zero_wait_fetch();
        FETCH = 1'b1; step();
        FETCH = 1'b0; IMEM_ACK = 1'b1; IMEM_RDATA = 32'h8123_0004;
        checks++; if (IMEM_REQ !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL zw_req got req=%b busy=%b want 1/1", IMEM_REQ, BUSY); end
        checks++; if (IMEM_ADDR !== 16'h0) begin errors++; $display("FAIL zw_addr got %h want 0000", IMEM_ADDR); end
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL zw_early_valid got %b want 0", INSTR_VALID); end
        step(); IMEM_ACK = 1'b0;
        checks++; if (INSTR_VALID !== 1'b1) begin errors++; $display("FAIL zw_valid got %b want 1", INSTR_VALID); end
        checks++; if (OPCODE !== 4'h8 || MM !== 4'h1) begin errors++; $display("FAIL zw_fields got op=%h mm=%h want 8/1", OPCODE, MM); end
        checks++; if (INSTR !== 32'h8123_0004) begin errors++; $display("FAIL zw_instr got %h want 81230004", INSTR); end
        checks++; if (PC !== 16'h0 || IMEM_REQ !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL zw_after got pc=%h req=%b busy=%b want 0/0/0", PC, IMEM_REQ, BUSY); end
        step();
        checks++; if (INSTR_VALID !== 1'b0) begin errors++; $display("FAIL zw_pulse got %b want 0", INSTR_VALID); end
    endtask

    task automatic test_pc_update();
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] exp_pc;
        load_instr(32'h0000_FFFF);
        PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b1; step();
        checks++; if (PC !== 16'hFFFF) begin errors++; $display("FAIL pc_abs_ffff got %h want ffff", PC); end
        PC_SEL = 1'b0; step(); PC_WRITE = 1'b0;
        checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h want 0000", PC); end
        load_instr(32'h6000_0010); set_pc(5);
        PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b0; step(); PC_WRITE = 1'b0;
        checks++; if (PC !== 16'h0015) begin errors++; $display("FAIL pc_rel_fwd got %h want 0015", PC); end
        load_instr(32'h0000_FFFE); set_pc(8);
        PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b0; step(); PC_WRITE = 1'b0;
        checks++; if (PC !== 16'h0006) begin errors++; $display("FAIL pc_rel_back got %h want 0006", PC); end
        load_instr(32'h0000_0040);
        PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'b1; step(); PC_WRITE = 1'b0;
        checks++; if (PC !== 16'h0040) begin errors++; $display("FAIL pc_abs got %h want 0040", PC); end
        PC_RST = 1'b1; PC_WRITE = 1'b1; PC_SEL = 1'b0; step(); PC_RST = 1'b0; PC_WRITE = 1'b0;
        checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL pc_rst_prio got %h want 0000", PC); end
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            load_instr(d);
            PC_WRITE = 1'b1; PC_SEL = 1'b1; BR_SEL = 1'($urandom_range(0, 1));
            exp_pc = BR_SEL ? d[15:0] : ADDR_W'(int'(PC) + int'($signed(d[15:0])));
            step(); PC_WRITE = 1'b0;
            checks++; if (PC !== exp_pc) begin errors++; $display("FAIL pc_rand_branch got %h want %h", PC, exp_pc); end
        end
    endtask

    task automatic test_wait_fetch();
        logic [DATA_W-1:0] d;
        int nvalid;
        set_pc(3);
        FETCH = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 16'h0003 || BUSY !== 1'b1 || INSTR_VALID !== 1'b0)
                begin errors++; $display("FAIL wait_hold[%0d] got req=%b addr=%h busy=%b v=%b want 1/0003/1/0", i, IMEM_REQ, IMEM_ADDR, BUSY, INSTR_VALID); end
            PC_WRITE = (i == 1); PC_SEL = 1'b0;
            step();
        end
        PC_WRITE = 1'b0; FETCH = 1'b0;
        d = $urandom; IMEM_ACK = 1'b1; IMEM_RDATA = d; step(); IMEM_ACK = 1'b0;
        checks++; if (INSTR !== d) begin errors++; $display("FAIL wait_instr got %h want %h", INSTR, d); end
        nvalid = int'(INSTR_VALID);
        repeat (3) begin step(); nvalid += int'(INSTR_VALID); end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL wait_one_valid got %0d want 1", nvalid); end
        checks++; if (PC !== 16'h0004 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL wait_pc got pc=%h req=%b want 0004/0", PC, IMEM_REQ); end
    endtask

    task automatic test_rst_abort();
        FETCH = 1'b1; step(); FETCH = 1'b0; step(); step();
        RST = 1'b1; step(); RST = 1'b0;
        checks++; if (IMEM_REQ !== 1'b0 || BUSY !== 1'b0 || INSTR !== 32'h0) begin errors++; $display("FAIL abort_state got req=%b busy=%b instr=%h want 0/0/0", IMEM_REQ, BUSY, INSTR); end
        IMEM_ACK = 1'b1; IMEM_RDATA = $urandom; step(); IMEM_ACK = 1'b0;
        checks++; if (INSTR_VALID !== 1'b0 || INSTR !== 32'h0) begin errors++; $display("FAIL abort_late_ack got v=%b instr=%h want 0/0", INSTR_VALID, INSTR); end
        step();
        checks++; if (INSTR_VALID !== 1'b0 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL abort_quiet got v=%b req=%b want 0/0", INSTR_VALID, IMEM_REQ); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d;
        int nvalid = 0;
        FETCH = 1'b1; IMEM_ACK = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = $urandom; IMEM_RDATA = d; step();
            checks++; if (INSTR_VALID !== ((i % 2) == 1)) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", i, INSTR_VALID, (i % 2) == 1); end
            if (INSTR_VALID === 1'b1) begin
                nvalid++;
                checks++; if (INSTR !== d) begin errors++; $display("FAIL b2b_instr[%0d] got %h want %h", i, INSTR, d); end
            end
        end
        FETCH = 1'b0; IMEM_ACK = 1'b0; step();
        checks++; if (nvalid != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", nvalid); end
    endtask

    task automatic test_timeout();
        logic [DATA_W-1:0] d;
        RST = 1'b1; step(); RST = 1'b0;
        FETCH = 1'b1; step(); FETCH = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            checks++; if (BUSY !== 1'b1 || INSTR_VALID !== 1'b0) begin errors++; $display("FAIL to_wait[%0d] got busy=%b v=%b want 1/0", i, BUSY, INSTR_VALID); end
            step();
        end
        checks++; if (BUSY !== 1'b1 || FAULT !== 1'b0 || DBG_TIMER !== CNT_W'(TIMEOUT_CYC)) begin errors++; $display("FAIL to_pre got busy=%b fault=%b tmr=%0d want 1/0/%0d", BUSY, FAULT, DBG_TIMER, TIMEOUT_CYC); end
        step();
        checks++; if (INSTR !== 32'hF000_0000 || INSTR_VALID !== 1'b1 || OPCODE !== 4'hF) begin errors++; $display("FAIL to_halt got instr=%h v=%b want f0000000/1", INSTR, INSTR_VALID); end
        checks++; if (FAULT !== 1'b1 || IMEM_REQ !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL to_fault got fault=%b req=%b busy=%b want 1/0/0", FAULT, IMEM_REQ, BUSY); end
        load_instr(32'h1234_5678); step();
        checks++; if (FAULT !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", FAULT); end
        RST = 1'b1; step(); RST = 1'b0;
        FETCH = 1'b1; step(); FETCH = 1'b0;
        repeat (TIMEOUT_CYC) step();
        d = $urandom; IMEM_ACK = 1'b1; IMEM_RDATA = d; step(); IMEM_ACK = 1'b0;
        checks++; if (INSTR !== d || INSTR_VALID !== 1'b1 || FAULT !== 1'b0) begin errors++; $display("FAIL to_ack_wins got instr=%h v=%b fault=%b want %h/1/0", INSTR, INSTR_VALID, FAULT, d); end
`else
        repeat (100) step();
        checks++; if (IMEM_REQ !== 1'b1 || BUSY !== 1'b1 || FAULT !== 1'b0) begin errors++; $display("FAIL noto_hold got req=%b busy=%b fault=%b want 1/1/0", IMEM_REQ, BUSY, FAULT); end
        d = $urandom; IMEM_ACK = 1'b1; IMEM_RDATA = d; step(); IMEM_ACK = 1'b0;
        checks++; if (INSTR !== d || INSTR_VALID !== 1'b1) begin errors++; $display("FAIL noto_done got instr=%h v=%b want %h/1", INSTR, INSTR_VALID, d); end
`endif
        step();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] e;
        exp_q.delete();
        for (int i = 0; i < 800; i++) begin
            RST        = ($urandom_range(0, 99) == 0);
            PC_RST     = ($urandom_range(0, 15) == 0);
            PC_WRITE   = ($urandom_range(0, 9) < 4);
            PC_SEL     = 1'($urandom_range(0, 1));
            BR_SEL     = 1'($urandom_range(0, 1));
            FETCH      = 1'($urandom_range(0, 1));
            IMEM_ACK   = ($urandom_range(0, 9) < 2);
            IMEM_RDATA = $urandom;
            step();
            checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, PC, m_pc); end
            checks++; if (INSTR !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", i, INSTR, m_instr); end
            checks++; if (INSTR_VALID !== m_valid || BUSY !== m_busy || IMEM_REQ !== m_busy || DBG_STATE !== m_busy)
                begin errors++; $display("FAIL rnd_ctl[%0d] got v=%b busy=%b req=%b want v=%b busy=%b", i, INSTR_VALID, BUSY, IMEM_REQ, m_valid, m_busy); end
            checks++; if (FAULT !== m_fault) begin errors++; $display("FAIL rnd_fault[%0d] got %b want %b", i, FAULT, m_fault); end
            if (m_busy) begin
                checks++; if (IMEM_ADDR !== m_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", i, IMEM_ADDR, m_addr); end
            end
            if (INSTR_VALID === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_sb[%0d] got valid with instr %h want no completion", i, INSTR); end
                else begin
                    e = exp_q.pop_front();
                    if (INSTR !== e) begin errors++; $display("FAIL rnd_sb[%0d] got %h want %h", i, INSTR, e); end
                end
            end
        end
        RST = 1'b0; PC_RST = 1'b0; PC_WRITE = 1'b0; FETCH = 1'b0; IMEM_ACK = 1'b0;
        step();
        checks++; if (exp_q.size() > 1) begin errors++; $display("FAIL rnd_sb_left got %0d want <=1", exp_q.size()); end
    endtask

    initial begin
        RST = 1'b1; PC_RST = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0; BR_SEL = 1'b0;
        FETCH = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = '0;
        @(negedge CLK);
        test_reset();
        test_zero_wait_fetch();
        test_pc_update();
        test_wait_fetch();
        test_rst_abort();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and program-counter datapath block. It responds to the multi-cycle controller's PC control strobes (PC_RST, PC_WRITE, PC_SEL, BR_SEL) and holds the program counter. On a fetch strobe it reads an instruction word from instruction memory over a request/acknowledge handshake and latches it in the instruction register. It returns OPCODE and MM fields to the controller.

## Interface
- ADDR_W, 16, program counter and instruction-memory address width; also the width of the branch target/offset field INSTR[ADDR_W-1:0].
- DATA_W, 32, instruction width; OPCODE = INSTR[DATA_W-1:DATA_W-4], MM = INSTR[DATA_W-5:DATA_W-8].
- TIMEOUT_CYC, 15, acknowledge timeout in cycles; used only with FETCH_TIMEOUT_EN.

- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; one clock, reset is synchronous and active-high.
- PC_RST  in  1  synchronous PC clear request from controller.
- PC_WRITE  in  1  load PC this edge.
- PC_SEL  in  1  0 = PC+1, 1 = branch target.
- BR_SEL  in  1  1 = absolute target, 0 = PC-relative target.
- FETCH  in  1  start instruction fetch at current PC.
- IMEM_REQ  out  1  memory read request, held until acknowledged.
- IMEM_ADDR  out  ADDR_W  read address, stable while IMEM_REQ=1.
- IMEM_RDATA  in  DATA_W  read data, valid when IMEM_ACK=1.
- IMEM_ACK  in  1  read acknowledge.
- INSTR  out  DATA_W  instruction register.
- OPCODE  out  4  INSTR opcode field.
- MM  out  4  INSTR mode/mask field.
- PC  out  ADDR_W  program counter.
- INSTR_VALID  out  1  one-cycle pulse: INSTR updated this cycle.
- BUSY  out  1  fetch outstanding.
- FAULT  out  1  sticky fetch timeout flag.

## Operation
- Reset values: PC=0, INSTR=0, IMEM_REQ=0, IMEM_ADDR=0, INSTR_VALID=0, BUSY=0, FAULT=0, state IDLE, timeout counter 0.
- PC update precedence per edge is RST, then PC_RST (PC<=0), then PC_WRITE, then hold.
- PC_WRITE with PC_SEL=0: PC <= PC+1, wrapping modulo 2^ADDR_W (all-ones wraps to 0).
- PC_WRITE with PC_SEL=1 and BR_SEL=1: PC <= INSTR[ADDR_W-1:0].
- PC_WRITE with PC_SEL=1 and BR_SEL=0: PC <= PC + signed INSTR[ADDR_W-1:0], wrapping modulo 2^ADDR_W.
- Targets always come from the latched INSTR, never from IMEM_RDATA.
- FSM IDLE: IMEM_ACK is ignored. FETCH=1 moves to WAIT, with IMEM_ADDR<=PC (the pre-update value if PC_WRITE is in the same cycle) and IMEM_REQ<=1.
- FSM WAIT: IMEM_REQ and IMEM_ADDR are held. FETCH is ignored. PC updates still occur and do not disturb IMEM_ADDR.
- WAIT, IMEM_ACK=1: INSTR<=IMEM_RDATA, IMEM_REQ<=0, INSTR_VALID<=1 for one cycle, return to IDLE.
- BUSY=1 exactly while in WAIT.
- RST in WAIT aborts the fetch: IMEM_REQ drops after the edge, and a late IMEM_ACK is ignored because the block is in IDLE.

## Timing
- FETCH sampled at edge n: IMEM_REQ=1 and BUSY=1 from n+1.
- IMEM_ACK sampled high at edge m (m ≥ n+1): INSTR, OPCODE and MM update after m, INSTR_VALID=1 for the cycle after m only, IMEM_REQ=0 and BUSY=0 after m.
- Minimum FETCH-to-INSTR_VALID latency is 2 edges.
- FETCH asserted in the cycle after completion is accepted, giving back-to-back fetches every 2 cycles with zero-wait memory.
- PC updates are visible on PC one edge after PC_WRITE/PC_RST.

## Configuration
- FETCH_TIMEOUT_EN defined: a counter runs in WAIT. If TIMEOUT_CYC edges pass without IMEM_ACK, then on the next edge:
  - IMEM_REQ<=0
  - INSTR<={4'hF, zeros} (the halt opcode)
  - INSTR_VALID pulses
  - FAULT<=1, sticky until RST
  - state returns to IDLE
- IMEM_ACK arriving on the timeout edge wins: normal completion, no fault.
- FETCH_TIMEOUT_EN undefined: WAIT persists indefinitely, FAULT is tied 0, and no counter is built.

## Test plan
- Reset, then FETCH with IMEM_ACK high immediately and RDATA=32'h8123_0004 -> IMEM_ADDR=0, INSTR_VALID 2 edges after FETCH, OPCODE=8, MM=1, PC still 0.
- PC_WRITE with PC_SEL=0 at PC=16'hFFFF -> PC=0. Then INSTR=32'h6000_0010, PC=5, PC_WRITE, PC_SEL=1, BR_SEL=0 -> PC=16'h0015.
- INSTR low field 16'hFFFE at PC=8, relative branch -> PC=6. Absolute branch with field 16'h0040 -> PC=16'h0040.
- FETCH at PC=3, ack delayed 4 cycles, PC_WRITE and extra FETCH during WAIT -> IMEM_ADDR stays 3, one INSTR_VALID, PC advanced to 4.
- RST asserted mid-WAIT, then IMEM_ACK pulsed -> IMEM_REQ=0, INSTR=0, no INSTR_VALID.
- With FETCH_TIMEOUT_EN, TIMEOUT_CYC=15, no ack -> after 15 edges in WAIT, next edge gives INSTR=32'hF000_0000, INSTR_VALID, FAULT=1. Without the macro, REQ is still high after 100 cycles and FAULT=0.
